// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter: one shared WIDTH-bit register written by NREQ requesters.
// A round-robin arbiter picks one writer per cycle. A writer may lock the
// register and keep ownership for a multi-cycle burst.
module rr_reg_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*WIDTH-1:0] data,
    output logic [NREQ-1:0]       grant,
    output logic [WIDTH-1:0]      out,
    output logic                  out_valid,
    output logic [IDW-1:0]        out_id,
    output logic                  locked
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e             state_q;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     owner_q;
    logic [WIDTH-1:0]   out_q;
    logic               out_valid_q;
    logic [IDW-1:0]     out_id_q;
    logic               locked_q;

    logic [IDW:0]       cand;
    logic               found;
    logic [IDW-1:0]     win_idx;
    logic               write_en;
    logic [WIDTH-1:0]   sel_data;

    // Wraps at NREQ rather than 2^IDW so non-power-of-two counts rotate correctly.
    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        return (i == IDW'(NREQ - 1)) ? '0 : i + IDW'(1);
    endfunction

    // Pick this cycle's winner: the lock owner, or the first requester from ptr onward.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        if (!reset) begin
            if (state_q == StLocked) begin
                win_idx = owner_q;
                found   = req[owner_q];
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    cand = {1'b0, ptr_q} + (IDW+1)'(k);
                    if (cand >= (IDW+1)'(NREQ)) begin
                        cand = cand - (IDW+1)'(NREQ);
                    end
                    if (!found && req[cand[IDW-1:0]]) begin
                        found   = 1'b1;
                        win_idx = cand[IDW-1:0];
                    end
                end
            end
            if (found) begin
                grant[win_idx] = 1'b1;
            end
        end
    end

    assign write_en = |grant;

    // Write mux: grant is one-hot, so at most one slice is selected.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_data = data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Register capture plus the IDLE/LOCKED ownership FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            owner_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            locked_q    <= 1'b0;
        end else begin
            if (write_en) begin
                out_q       <= sel_data;
                out_id_q    <= win_idx;
                out_valid_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (write_en) begin
                        if (lock[win_idx]) begin
                            state_q  <= StLocked;
                            locked_q <= 1'b1;
                            owner_q  <= win_idx;
                        end else begin
                            ptr_q <= next_idx(win_idx);
                        end
                    end
                end
                StLocked: begin
                    // Leave on an unlocked final write or when the owner stops requesting.
                    if (!(req[owner_q] && lock[owner_q])) begin
                        state_q  <= StIdle;
                        locked_q <= 1'b0;
                        ptr_q    <= next_idx(owner_q);
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Bench for rr_reg_arbiter: an NREQ=4 and an NREQ=3 instance driven side by side,
// checked against a queue-based scoreboard fed by a behavioural model.
module tb_rr_reg_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req0, lock0;
    logic [127:0] data0;
    logic [2:0]   req1, lock1;
    logic [95:0]  data1;

    logic [3:0]   grant0;
    logic [31:0]  out0;
    logic         out_valid0;
    logic [1:0]   out_id0;
    logic         locked0;
    logic [2:0]   grant1;
    logic [31:0]  out1;
    logic         out_valid1;
    logic [1:0]   out_id1;
    logic         locked1;

    rr_reg_arbiter #(.WIDTH(32), .NREQ(4)) dut4 (
        .clk(clk), .reset(reset), .req(req0), .lock(lock0), .data(data0),
        .grant(grant0), .out(out0), .out_valid(out_valid0), .out_id(out_id0),
        .locked(locked0)
    );

    rr_reg_arbiter #(.WIDTH(32), .NREQ(3)) dut3 (
        .clk(clk), .reset(reset), .req(req1), .lock(lock1), .data(data1),
        .grant(grant1), .out(out1), .out_valid(out_valid1), .out_id(out_id1),
        .locked(locked1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  grant;
        logic [31:0] out;
        logic        vld;
        logic [1:0]  id;
        logic        lk;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    // Model state per instance: pointer, lock flag, owner and the stored register.
    int          nreq[2] = '{4, 3};
    int          m_ptr[2];
    bit          m_lk[2];
    int          m_own[2];
    logic [31:0] m_out[2];
    bit          m_vld[2];
    int          m_id[2];

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset(input int d);
        m_ptr[d] = 0; m_lk[d] = 0; m_own[d] = 0;
        m_out[d] = '0; m_vld[d] = 0; m_id[d] = 0;
    endtask

    // Apply inputs for one instance, queue what it must show this cycle, advance the model.
    task automatic drive(input int d, input bit rst, input logic [3:0] r, input logic [3:0] l,
                         input logic [127:0] dat);
        exp_t e;
        int   w;
        int   n;
        n = nreq[d];
        reset = rst;
        if (d == 0) begin
            req0 = r; lock0 = l; data0 = dat;
        end else begin
            req1 = r[2:0]; lock1 = l[2:0]; data1 = dat[95:0];
            r[3] = 1'b0; l[3] = 1'b0;
        end
        w = -1;
        if (!rst) begin
            if (m_lk[d]) begin
                if (r[m_own[d]]) w = m_own[d];
            end else begin
                for (int k = 0; k < n; k++) begin
                    if (w < 0 && r[(m_ptr[d] + k) % n]) w = (m_ptr[d] + k) % n;
                end
            end
        end
        e.grant = (w >= 0) ? 4'(1 << w) : 4'b0;
        e.out   = m_out[d];
        e.vld   = m_vld[d];
        e.id    = 2'(m_id[d]);
        e.lk    = m_lk[d];
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);

        if (rst) begin
            model_reset(d);
        end else begin
            if (w >= 0) begin
                m_out[d] = dat[w*32 +: 32];
                m_vld[d] = 1;
                m_id[d]  = w;
            end
            if (m_lk[d]) begin
                if (w < 0 || !l[m_own[d]]) begin
                    m_lk[d]  = 0;
                    m_ptr[d] = (m_own[d] + 1) % n;
                end
            end else if (w >= 0) begin
                if (l[w]) begin
                    m_lk[d]  = 1;
                    m_own[d] = w;
                end else begin
                    m_ptr[d] = (w + 1) % n;
                end
            end
        end
    endtask

    task automatic cyc(input bit rs, input logic [3:0] r0, input logic [3:0] l0,
                       input logic [127:0] d0, input logic [3:0] r1, input logic [3:0] l1);
        drive(0, rs, r0, l0, d0);
        drive(1, rs, r1, l1, rnd128());
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int d, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s actual %h required %h", d, name, act, exp);
        end
    endtask

    task automatic compare(input int d, input exp_t e, input exp_t a);
        chk(d, "grant", 32'(a.grant), 32'(e.grant));
        chk(d, "out", a.out, e.out);
        chk(d, "out_valid", 32'(a.vld), 32'(e.vld));
        chk(d, "out_id", 32'(a.id), 32'(e.id));
        chk(d, "locked", 32'(a.lk), 32'(e.lk));
    endtask

    exp_t e_mon;
    exp_t a_mon;

    // Monitor: pops one expectation per instance each cycle, mid-cycle.
    always @(negedge clk) begin
        if (q0.size() > 0) begin
            e_mon = q0.pop_front();
            a_mon = {grant0, out0, out_valid0, out_id0, locked0};
            compare(0, e_mon, a_mon);
        end
        if (q1.size() > 0) begin
            e_mon = q1.pop_front();
            a_mon = {1'b0, grant1, out1, out_valid1, out_id1, locked1};
            compare(1, e_mon, a_mon);
        end
    end

    logic [127:0] dv;

    initial begin
        reset = 1'b1;
        req0 = '0; lock0 = '0; data0 = '0;
        req1 = '0; lock1 = '0; data1 = '0;
        @(posedge clk);
        #1;
        model_reset(0);
        model_reset(1);

        // Second reset cycle, then idle.
        cyc(1, 4'b0, 4'b0, rnd128(), 4'b0, 4'b0);
        repeat (3) cyc(0, 4'b0, 4'b0, rnd128(), 4'b0, 4'b0);

        // Single writer on slot 2; NREQ=3 instance moves its pointer to 2.
        dv = rnd128();
        dv[64 +: 32] = 32'hDEADBEEF;
        cyc(0, 4'b0100, 4'b0, dv, 4'b010, 4'b0);

        // Return pointer to 0 via slot 3, then full contention; NREQ=3 wrap case.
        cyc(0, 4'b1000, 4'b0, rnd128(), 4'b101, 4'b0);
        cyc(0, 4'b0, 4'b0, rnd128(), 4'b101, 4'b0);
        cyc(0, 4'b0, 4'b0, rnd128(), 4'b101, 4'b0);
        repeat (8) cyc(0, 4'b1111, 4'b0, rnd128(), 4'b0, 4'b0);

        // Lock burst by 1 with 3 waiting, unlocked final write, then 3 wins.
        repeat (3) cyc(0, 4'b1010, 4'b0010, rnd128(), 4'b0, 4'b0);
        cyc(0, 4'b1010, 4'b0, rnd128(), 4'b0, 4'b0);
        cyc(0, 4'b1010, 4'b0, rnd128(), 4'b0, 4'b0);

        // Owner drop: lock on 1, then only requester 0 remains.
        cyc(0, 4'b0010, 4'b0010, rnd128(), 4'b0, 4'b0);
        cyc(0, 4'b0001, 4'b0, rnd128(), 4'b0, 4'b0);
        cyc(0, 4'b0001, 4'b0, rnd128(), 4'b0, 4'b0);

        // Reset while locked.
        cyc(0, 4'b0100, 4'b0100, rnd128(), 4'b001, 4'b001);
        cyc(0, 4'b0100, 4'b0100, rnd128(), 4'b001, 4'b001);
        cyc(1, 4'b0100, 4'b0100, rnd128(), 4'b001, 4'b001);
        cyc(0, 4'b0, 4'b0, rnd128(), 4'b0, 4'b0);

        // Random traffic with occasional locks and rare resets.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 63) == 0), 4'($urandom), 4'($urandom & $urandom),
                rnd128(), 4'($urandom), 4'($urandom & $urandom));
        end

        @(negedge clk);
        #1;
        if (q0.size() != 0 || q1.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain actual %0d/%0d left required 0/0",
                     q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_reg_arbiter.md
Name: rr_reg_arbiter

Overview:
- Shares one WIDTH-bit storage register among NREQ requesters.
- Each cycle, a round-robin arbiter picks one requester. Its data is steered through the internal write mux and captured in the register.
- Supports an optional lock, so one requester can hold the register for a multi-cycle burst.
- Sits between pipeline stages that contend for a single shared register instance.

Parameters:
- WIDTH, 32, data width of each requester and of the stored value.
- NREQ, 4, number of requesters; legal range 2..16, need not be a power of two.
- IDW, $clog2(NREQ), width of the requester index; do not override.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  bit i high: requester i wants to write this cycle.
- lock  input  NREQ  bit i high together with req[i]: requester i asks to keep ownership after this write.
- data  input  NREQ*WIDTH  requester i's data in bits [i*WIDTH +: WIDTH].
- grant  output  NREQ  one-hot (or zero) combinational grant for the current cycle.
- out  output  WIDTH  stored register value.
- out_valid  output  1  register holds at least one write since reset.
- out_id  output  IDW  index of the requester that performed the last write.
- locked  output  1  FSM is in LOCKED state.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. On a posedge with reset high:
  - out=0, out_valid=0, out_id=0, locked=0.
  - Priority pointer ptr=0, state=IDLE, owner=0.
- Grant during reset: grant is forced to 0 while reset is high, and reset overrides every other event that cycle.
- State IDLE:
  - If req==0: grant=0 and no write.
  - Otherwise grant the first i with req[i]=1, searching ptr, ptr+1, ..., wrapping mod NREQ.
  - grant is combinational in the same cycle as req. There is no grant without req.
- State LOCKED (owner o):
  - grant[o]=req[o]. All other grant bits are 0, even if those requesters are waiting.
- Write:
  - write_en = |grant. The mux selects data of the granted index.
  - At the next posedge: out <= selected data, out_id <= index, out_valid <= 1.
  - Latency is 1 cycle from grant to out.
  - With no grant, out, out_id and out_valid hold.
- Transitions:
  - IDLE to LOCKED when the winner w has lock[w]=1. Set owner <= w; ptr is unchanged.
  - IDLE to IDLE when the winner has lock=0. Set ptr <= (w+1) mod NREQ.
  - LOCKED to LOCKED while req[o]&&lock[o]. A write occurs each cycle.
  - LOCKED to IDLE when req[o]&&!lock[o]. This final write occurs; set ptr <= (o+1) mod NREQ.
  - LOCKED to IDLE when !req[o]. No write; set ptr <= (o+1) mod NREQ.
- locked output: registered, and equals (state==LOCKED).
- Wrap-around: the ptr increment wraps at NREQ, not at 2^IDW. For example, with NREQ=3, ptr=2 advances to 0.
- Simultaneous requests: exactly one grant per cycle. Each requester that holds req continuously is granted within NREQ grant cycles when no lock is held.
- Ignored inputs: lock bits of non-granted requesters have no effect. data of non-granted requesters has no effect.
- Reset mid-burst: reset in LOCKED returns to IDLE with ptr=0 on the next edge. No write occurs that cycle.

Test Plan:
- Reset, then idle: hold reset 2 cycles, then req=0 for 3 cycles -> out=0, out_valid=0, out_id=0, grant=0, locked=0 throughout.
- Single writer: req=4'b0100, data[2]=32'hDEADBEEF, lock=0 for one cycle -> grant=4'b0100 that cycle; next cycle out=32'hDEADBEEF, out_id=2, out_valid=1, ptr=3.
- Round-robin fairness: req=4'b1111 held 8 cycles, no lock, ptr=0 -> grant sequence 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000; out_id lags grant by 1 cycle.
- Lock burst: req[1] and lock[1] high for 3 cycles with req[3] also high, then lock[1] low for 1 cycle:
  - grant[1] is high on all 4 cycles.
  - locked=1 on cycles 2-4.
  - Requester 3 is granted on cycle 5.
- Owner drop: in LOCKED with owner 1, drop req[1] while req[0]=1 -> that cycle grant=0 and out holds; next cycle IDLE, ptr=2, and grant=4'b0001 (search 2, 3, 0).
- Reset mid-lock and NREQ=3 wrap:
  - Assert reset during LOCKED -> locked=0, out=0, ptr=0 next cycle.
  - With NREQ=3, req=3'b101 and ptr=2 -> grant 100, then 001, then 100.
